// File: rtl/approx_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module  : approx_mul_pkg
// Brief   : Shared widths and sweep-state encoding for the approximate
//           multiplier error-characterisation harness.
// Rev     : 1.0  initial release
// ============================================================================
package approx_mul_pkg;

  localparam int W     = 8;      // operand width
  localparam int PW    = 2 * W;  // product / error-distance width
  localparam int ACC_W = 4 * W;  // error-distance sum width (cannot overflow)

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/approx_mul_err_sweep_err_dist.sv
`default_nettype none
// ============================================================================
// Module  : err_dist
// Brief   : Stage 1 of the sweep pipeline. Captures an operand pair and the
//           multiplier's product, then registers the absolute distance
//           between the exact product and the sampled one. The operands
//           travel alongside the distance so the worst pair can be recorded.
// Rev     : 1.0  initial release
// ============================================================================
module err_dist #(
  parameter int W = approx_mul_pkg::W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  input  logic [2*W-1:0] prod,
  output logic           out_valid,
  output logic [2*W-1:0] ed,
  output logic [W-1:0]   ed_a,
  output logic [W-1:0]   ed_b
);

  localparam int c_pw = 2 * W;

  logic            r_cap_v;
  logic [W-1:0]    r_cap_a;
  logic [W-1:0]    r_cap_b;
  logic [c_pw-1:0] r_cap_p;

  logic            r_ed_v;
  logic [c_pw-1:0] r_ed;
  logic [W-1:0]    r_ed_a;
  logic [W-1:0]    r_ed_b;

  logic [c_pw-1:0] w_exact;
  logic [c_pw-1:0] w_ed;

  // Exact product of the captured pair and its unsigned distance to the sample
  always_comb begin
    w_exact = {{W{1'b0}}, r_cap_a} * {{W{1'b0}}, r_cap_b};
    w_ed    = (w_exact >= r_cap_p) ? (w_exact - r_cap_p) : (r_cap_p - w_exact);
  end

  // Capture the pair on sampling cycles, then register its error distance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cap_v <= 1'b0;
      r_cap_a <= '0;
      r_cap_b <= '0;
      r_cap_p <= '0;
      r_ed_v  <= 1'b0;
      r_ed    <= '0;
      r_ed_a  <= '0;
      r_ed_b  <= '0;
    end else begin
      r_cap_v <= in_valid;
      if (in_valid) begin
        r_cap_a <= a;
        r_cap_b <= b;
        r_cap_p <= prod;
      end
      r_ed_v <= r_cap_v;
      if (r_cap_v) begin
        r_ed   <= w_ed;
        r_ed_a <= r_cap_a;
        r_ed_b <= r_cap_b;
      end
    end
  end

  assign out_valid = r_ed_v;
  assign ed        = r_ed;
  assign ed_a      = r_ed_a;
  assign ed_b      = r_ed_b;

endmodule
`default_nettype wire

// File: rtl/approx_mul_err_sweep.sv
`default_nettype none
// ============================================================================
// Module  : approx_mul_err_sweep
// Brief   : Exhaustive operand sweep around an external combinational
//           approximate multiplier. Drives every (a, b) pair, samples the
//           returned product and accumulates error count, error-distance sum,
//           and the first worst-case pair.
// Rev     : 1.0  initial release
// ============================================================================
module approx_mul_err_sweep
  import approx_mul_pkg::*;
#(
  parameter int W = approx_mul_pkg::W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           en,
  output logic [W-1:0]   a,
  output logic [W-1:0]   b,
  input  logic [2*W-1:0] prod8,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   err_cnt,
  output logic [4*W-1:0] sum_ed,
  output logic [2*W-1:0] max_ed,
  output logic [W-1:0]   worst_a,
  output logic [W-1:0]   worst_b
);

  localparam int c_pw    = 2 * W;
  localparam int c_acc_w = 4 * W;
  localparam int c_cw    = 2 * W + 1;

  sweep_state_t     r_state;
  logic [c_pw-1:0]  r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_drain;

  logic [c_cw-1:0]  r_err_cnt;
  logic [c_acc_w-1:0] r_sum_ed;
  logic [c_pw-1:0]  r_max_ed;
  logic [W-1:0]     r_worst_a;
  logic [W-1:0]     r_worst_b;

  logic             w_accept;
  logic             w_take;
  logic             w_ed_v;
  logic [c_pw-1:0]  w_ed;
  logic [W-1:0]     w_ed_a;
  logic [W-1:0]     w_ed_b;

  // A new sweep may only begin once the previous one has fully retired
  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  // A sample is taken on every enabled RUN cycle
  assign w_take   = (r_state == RUN) && en;

  // The sweep index doubles as the operand register: b varies fastest
  assign a = r_idx[c_pw-1:W];
  assign b = r_idx[W-1:0];

  err_dist #(
    .W (W)
  ) u_err_dist (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w_take),
    .a         (a),
    .b         (b),
    .prod      (prod8),
    .out_valid (w_ed_v),
    .ed        (w_ed),
    .ed_a      (w_ed_a),
    .ed_b      (w_ed_b)
  );

  // Sweep sequencer: index advance, two-cycle drain and done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_drain <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_state <= RUN;
            r_idx   <= '0;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (en) begin
            r_idx <= r_idx + c_pw'(1);
            if (r_idx == {c_pw{1'b1}}) begin
              r_state <= DRAIN;
              r_drain <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Two drain cycles retire the last capture and its accumulation
          if (r_drain) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stage 2: fold each valid error distance into the running statistics
  always_ff @(posedge clk) begin
    if (rst || w_accept) begin
      r_err_cnt <= '0;
      r_sum_ed  <= '0;
      r_max_ed  <= '0;
      r_worst_a <= '0;
      r_worst_b <= '0;
    end else if (w_ed_v) begin
      r_sum_ed <= r_sum_ed + c_acc_w'(w_ed);
      if (w_ed != '0) begin
        r_err_cnt <= r_err_cnt + c_cw'(1);
      end
      // Strict comparison keeps the earliest pair on a tie
      if (w_ed > r_max_ed) begin
        r_max_ed  <= w_ed;
        r_worst_a <= w_ed_a;
        r_worst_b <= w_ed_b;
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign err_cnt = r_err_cnt;
  assign sum_ed  = r_sum_ed;
  assign max_ed  = r_max_ed;
  assign worst_a = r_worst_a;
  assign worst_b = r_worst_b;

endmodule
`default_nettype wire

// File: tb/tb_approx_mul_err_sweep.sv
`default_nettype none
// ============================================================================
// Module  : tb_approx_mul_err_sweep
// Brief   : Self-checking bench for approx_mul_err_sweep. A behavioural
//           multiplier model drives prod8; expected statistics come from a
//           plain loop over the operand space in sweep order.
// Rev     : 1.0  initial release
// ============================================================================
module tb_approx_mul_err_sweep;

  localparam int TW    = 6;
  localparam int TPW   = 2 * TW;
  localparam int ACC   = 4 * TW;
  localparam int CW    = 2 * TW + 1;
  localparam int N     = 1 << TPW;
  localparam int PMAX  = (1 << TPW) - 1;
  localparam int LIMIT = N + 2000 + 100;
  localparam int LOWS  = 1000;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           en;
  logic [TW-1:0]  a;
  logic [TW-1:0]  b;
  logic [TPW-1:0] prod8;
  logic           busy;
  logic           done;
  logic [CW-1:0]  err_cnt;
  logic [ACC-1:0] sum_ed;
  logic [TPW-1:0] max_ed;
  logic [TW-1:0]  worst_a;
  logic [TW-1:0]  worst_b;

  int errors = 0;
  int checks = 0;
  int mode   = 0;
  int k1     = 1;
  int k2     = 1;

  approx_mul_err_sweep #(
    .W (TW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .en      (en),
    .a       (a),
    .b       (b),
    .prod8   (prod8),
    .busy    (busy),
    .done    (done),
    .err_cnt (err_cnt),
    .sum_ed  (sum_ed),
    .max_ed  (max_ed),
    .worst_a (worst_a),
    .worst_b (worst_b)
  );

  always #5 clk = ~clk;

  // Multiplier under test: 0 exact, 1 tied to zero, 2 a*b+1 saturating,
  // 3 exact plus a small operand-dependent offset, clamped to range
  function automatic int approx_fn(input int m, input int x, input int y,
                                   input int p1, input int p2);
    int v;
    v = x * y;
    case (m)
      0: ;
      1: v = 0;
      2: v = (v + 1 > PMAX) ? PMAX : v + 1;
      default: begin
        v = v + ((x * p1 + y * p2) % 7) - 3;
        if (v < 0) v = 0;
        if (v > PMAX) v = PMAX;
      end
    endcase
    return v;
  endfunction

  always_comb prod8 = TPW'(approx_fn(mode, int'(a), int'(b), k1, k2));

  // Reference statistics over the first nidx pairs in sweep order
  task automatic model(input int m, input int nidx, output longint cnt,
                       output longint sum, output longint mx,
                       output int wa, output int wb);
    cnt = 0; sum = 0; mx = 0; wa = 0; wb = 0;
    for (int i = 0; i < nidx; i++) begin
      int x, y, e;
      x = i / (1 << TW);
      y = i % (1 << TW);
      e = x * y - approx_fn(m, x, y, k1, k2);
      if (e < 0) e = -e;
      sum += e;
      if (e != 0) cnt++;
      if (e > mx) begin
        mx = e; wa = x; wb = y;
      end
    end
  endtask

  // Start a sweep and run it to the done pulse; lat counts edges after the
  // accepting edge until done is seen
  task automatic run_sweep(input bit tog, input bit pulse, output int lat,
                           output logic busy0, output logic [CW-1:0] cnt0,
                           output logic done_after);
    int highs, lows;
    en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy; cnt0 = err_cnt;
    lat = 0; highs = 0; lows = 0;
    while (done !== 1'b1 && lat < LIMIT) begin
      en = 1'b1; start = 1'b0;
      if (tog && highs < N && lows < LOWS &&
          ($urandom_range(0, 1) == 0 || highs >= N / 2)) en = 1'b0;
      if (pulse && highs < N && (lat % 300) == 150) start = 1'b1;
      if (highs < N) begin
        if (en) highs++; else lows++;
      end
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0; en = 1'b1;
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (a !== '0)       begin errors++; $display("FAIL reset_a got=%0d want=0", a); end
    checks++; if (b !== '0)       begin errors++; $display("FAIL reset_b got=%0d want=0", b); end
    checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
    checks++; if (sum_ed !== '0)  begin errors++; $display("FAIL reset_sum_ed got=%0d want=0", sum_ed); end
    checks++; if (max_ed !== '0)  begin errors++; $display("FAIL reset_max_ed got=%0d want=0", max_ed); end
    checks++; if (worst_a !== '0) begin errors++; $display("FAIL reset_worst_a got=%0d want=0", worst_a); end
    checks++; if (worst_b !== '0) begin errors++; $display("FAIL reset_worst_b got=%0d want=0", worst_b); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // Plain full sweep for one multiplier model; checks timing and statistics
  task automatic test_sweep(input string name, input int m);
    int lat, wa, wb;
    logic busy0, dn;
    logic [CW-1:0] c0;
    longint ec, es, em;
    mode = m;
    run_sweep(1'b0, 1'b0, lat, busy0, c0, dn);
    model(m, N, ec, es, em, wa, wb);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL %s busy_after_start got=%b want=1", name, busy0); end
    checks++; if (lat != N + 2) begin errors++; $display("FAIL %s done_latency got=%0d want=%0d", name, lat, N + 2); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL %s done_width got=%b want=0", name, dn); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL %s busy_in_done got=%b want=0", name, busy); end
    checks++; if (err_cnt !== CW'(ec)) begin errors++; $display("FAIL %s err_cnt got=%0d want=%0d", name, err_cnt, ec); end
    checks++; if (sum_ed !== ACC'(es)) begin errors++; $display("FAIL %s sum_ed got=%0d want=%0d", name, sum_ed, es); end
    checks++; if (max_ed !== TPW'(em)) begin errors++; $display("FAIL %s max_ed got=%0d want=%0d", name, max_ed, em); end
    checks++; if (worst_a !== TW'(wa) || worst_b !== TW'(wb)) begin
      errors++; $display("FAIL %s worst got=(%0d,%0d) want=(%0d,%0d)", name, worst_a, worst_b, wa, wb);
    end
    repeat (4) @(posedge clk);
    #1;
    checks++; if (err_cnt !== CW'(ec) || sum_ed !== ACC'(es) || max_ed !== TPW'(em)) begin
      errors++; $display("FAIL %s hold got=%0d/%0d/%0d want=%0d/%0d/%0d", name, err_cnt, sum_ed, max_ed, ec, es, em);
    end
  endtask

  task automatic test_en_toggle();
    int lat, wa, wb;
    logic busy0, dn;
    logic [CW-1:0] c0;
    longint ec, es, em;
    mode = 0;
    run_sweep(1'b1, 1'b0, lat, busy0, c0, dn);
    model(0, N, ec, es, em, wa, wb);
    checks++; if (lat != N + 2 + LOWS) begin errors++; $display("FAIL en_toggle done_latency got=%0d want=%0d", lat, N + 2 + LOWS); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL en_toggle done_width got=%b want=0", dn); end
    checks++; if (err_cnt !== CW'(ec) || sum_ed !== ACC'(es) || max_ed !== TPW'(em)) begin
      errors++; $display("FAIL en_toggle stats got=%0d/%0d/%0d want=%0d/%0d/%0d", err_cnt, sum_ed, max_ed, ec, es, em);
    end
    checks++; if (worst_a !== TW'(wa) || worst_b !== TW'(wb)) begin
      errors++; $display("FAIL en_toggle worst got=(%0d,%0d) want=(%0d,%0d)", worst_a, worst_b, wa, wb);
    end
  endtask

  // start pulses mid-sweep are ignored; a later start re-clears and repeats
  task automatic test_start_during_run();
    int lat, wa, wb;
    logic busy0, dn;
    logic [CW-1:0] c0;
    longint ec, es, em;
    mode = 3;
    k1 = int'($urandom_range(1, 50));
    k2 = int'($urandom_range(1, 50));
    model(3, N, ec, es, em, wa, wb);
    for (int pass = 0; pass < 2; pass++) begin
      run_sweep(pass == 0, pass == 0, lat, busy0, c0, dn);
      if (pass == 0) begin
        checks++; if (lat != N + 2 + LOWS) begin errors++; $display("FAIL start_in_run done_latency got=%0d want=%0d", lat, N + 2 + LOWS); end
      end else begin
        checks++; if (lat != N + 2) begin errors++; $display("FAIL restart done_latency got=%0d want=%0d", lat, N + 2); end
        checks++; if (c0 !== '0) begin errors++; $display("FAIL restart cleared_err_cnt got=%0d want=0", c0); end
      end
      checks++; if (err_cnt !== CW'(ec) || sum_ed !== ACC'(es) || max_ed !== TPW'(em)) begin
        errors++; $display("FAIL start_pass%0d stats got=%0d/%0d/%0d want=%0d/%0d/%0d", pass, err_cnt, sum_ed, max_ed, ec, es, em);
      end
      checks++; if (worst_a !== TW'(wa) || worst_b !== TW'(wb)) begin
        errors++; $display("FAIL start_pass%0d worst got=(%0d,%0d) want=(%0d,%0d)", pass, worst_a, worst_b, wa, wb);
      end
    end
  endtask

  // Reset on edge 3000 of a zero-product sweep aborts it completely
  task automatic test_rst_mid();
    int wa, wb;
    longint ec, es, em;
    mode = 1;
    en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2999) begin
      @(posedge clk); #1;
    end
    // samples 0..2996 have reached the statistics by now
    model(1, 2997, ec, es, em, wa, wb);
    checks++; if (busy !== 1'b1 || err_cnt !== CW'(ec)) begin
      errors++; $display("FAIL rst_mid partial got busy=%b cnt=%0d want busy=1 cnt=%0d", busy, err_cnt, ec);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (a !== '0 || b !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL rst_mid ctrl got a=%0d b=%0d busy=%b done=%b want all 0", a, b, busy, done);
    end
    checks++; if (err_cnt !== '0 || sum_ed !== '0 || max_ed !== '0 || worst_a !== '0 || worst_b !== '0) begin
      errors++; $display("FAIL rst_mid stats got=%0d/%0d/%0d/(%0d,%0d) want all 0", err_cnt, sum_ed, max_ed, worst_a, worst_b);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || a !== '0) begin
      errors++; $display("FAIL rst_mid idle got busy=%b a=%0d want busy=0 a=0", busy, a);
    end
    test_sweep("after_rst", 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; en = 1'b0;
    test_reset();
    test_sweep("exact", 0);
    test_sweep("zero", 1);
    test_sweep("plus_one", 2);
    k1 = int'($urandom_range(1, 50));
    k2 = int'($urandom_range(1, 50));
    test_sweep("random_approx", 3);
    test_en_toggle();
    test_start_during_run();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
